edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Multi-channel edge-event scheduler. Synchronises N_CH asynchronous level inputs,
//  detects rising/falling edges per channel, and holds each detected edge as a pending
//  event. Pending events share one output event port through a round-robin arbiter
//  with a valid/ready handshake. Sits between raw GPIO/status lines and the event consumer.
// PARAMETERS
//  N_CH   4   number of input channels (2..16)
//  CH_W   2   width of channel index, = clog2(N_CH)
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst_n       in   1      asynchronous active-low reset
//  data_in     in   N_CH   raw level inputs, asynchronous to clk
//  rise_en     in   N_CH   per-channel rising-edge detect enable
//  fall_en     in   N_CH   per-channel falling-edge detect enable
//  evt_valid   out  1      event presented on evt_ch/evt_type
//  evt_ready   in   1      consumer accepts event
//  evt_ch      out  CH_W   channel index of presented event
//  evt_type    out  1      0 = rising edge, 1 = falling edge
//  ovf         out  N_CH   sticky per-channel overflow flag
//  ovf_clr     in   N_CH   per-channel overflow clear (1-cycle pulse)
// BEHAVIOUR
//  Reset (rst_n=0, async): sync/prev flops, pending, order, ovf, rr pointer = 0;
//   evt_valid=0, evt_ch=0, evt_type=0; FSM -> IDLE.
//  Input path per channel: sync1 <- data_in, sync2 <- sync1, prev <- sync2.
//   rise_det = sync2 & ~prev & rise_en; fall_det = ~sync2 & prev & fall_en.
//   Channel held high through reset release reports exactly one rise (prev resets to 0).
//  Pending: rise_pend/fall_pend per channel, set on detect, cleared on transfer of that
//   event. order bit per channel records which pending type is older.
//  Overflow: detect while same-type pending already set and not being cleared this
//   cycle -> ovf[i] <= 1; event is dropped (pending stays, no double count).
//   Detect in the same cycle that event is transferred -> pending stays 1, no ovf.
//   ovf_clr[i] and new overflow in same cycle -> ovf[i] stays 1 (set wins).
//  Arbiter FSM (2 states):
//   IDLE: if any pending, pick first channel with pending at or after rr pointer
//    (wrapping N_CH-1 -> 0); register evt_ch/evt_type (older type if both pending);
//    evt_valid <= 1; -> PRESENT. Else stay.
//   PRESENT: evt_valid, evt_ch, evt_type held stable until evt_ready=1.
//    On evt_valid & evt_ready: clear that pending bit, rr pointer <= evt_ch+1 (wrap),
//    evt_valid <= 0, -> IDLE. No back-to-back: one bubble cycle between events.
//  Disabling rise_en/fall_en does not clear already-pending events.
//  Latency: input change set up before posedge 0 -> pending set at posedge 2 ->
//   evt_valid high after posedge 3 (idle port, no contention).
//  Throughput: max one event per 2 cycles with evt_ready tied high.
//  Channel with both types pending is granted twice only across separate rr rounds.
// TESTING
//  T1 single rise: ch1 0->1, evt_ready=1 -> evt_valid high 3 cycles later, ch=1, type=0, 1 cycle.
//  T2 round robin: ch0..3 rise same cycle, ready=1 -> events ch 0,1,2,3 in order, 2 cycles apart.
//  T3 backpressure: ready=0 for 10 cycles -> evt_valid/ch/type stable; ready=1 -> single transfer.
//  T4 overflow: ch2 toggles 0->1->0->1 while ready=0 -> ovf[2]=1, one rise+one fall delivered, fall first? no: rise first (older); ovf_clr[2] -> ovf[2]=0.
//  T5 enables: fall_en=0, ch0 1->0 -> no event; rise_en=1 ch0 0->1 -> rise event only.
//  T6 reset mid-PRESENT: rst_n=0 while evt_valid=1 -> evt_valid=0 immediately, pending/ovf cleared.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronised per-channel edge detection feeding one
// round-robin arbitrated event port with a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   data_in[N_CH]       raw asynchronous level inputs
//   rise_en/fall_en     per-channel edge detect enables
//   evt_valid/evt_ready handshake of the shared event port
//   evt_ch/evt_type     presented channel and type (0 rise, 1 fall)
//   ovf/ovf_clr         sticky per-channel overflow flag and its clear
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] data_in,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_type,
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t          state;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] prev;
    logic [N_CH-1:0] rise_pend;
    logic [N_CH-1:0] fall_pend;
    // order[i] = 1 when the pending fall of channel i is older than its rise
    logic [N_CH-1:0] order;
    logic [N_CH-1:0] order_n;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] rr_next;

    logic [N_CH-1:0] rise_det;
    logic [N_CH-1:0] fall_det;
    logic [N_CH-1:0] clr_rise;
    logic [N_CH-1:0] clr_fall;
    logic [N_CH-1:0] rise_keep;
    logic [N_CH-1:0] fall_keep;
    logic [N_CH-1:0] rise_new;
    logic [N_CH-1:0] fall_new;
    logic [N_CH-1:0] any_pend;
    logic            xfer;

    logic            found;
    logic [CH_W-1:0] pick;
    logic            pick_type;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;

    assign rise_det = sync2 & ~prev & rise_en;
    assign fall_det = ~sync2 & prev & fall_en;
    assign xfer     = evt_valid & evt_ready;
    assign any_pend = rise_pend | fall_pend;

    always_comb begin
        clr_rise = '0;
        clr_fall = '0;
        for (int i = 0; i < N_CH; i++) begin
            clr_rise[i] = xfer && (evt_ch == CH_W'(i)) && !evt_type;
            clr_fall[i] = xfer && (evt_ch == CH_W'(i)) && evt_type;
        end
    end

    // keep: still pending after this cycle's transfer; new: detect that
    // lands in an empty slot (a detect into an occupied slot is dropped)
    assign rise_keep = rise_pend & ~clr_rise;
    assign fall_keep = fall_pend & ~clr_fall;
    assign rise_new  = rise_det & ~rise_keep;
    assign fall_new  = fall_det & ~fall_keep;

    // A newly queued type is younger than whatever type stays pending.
    assign order_n = (fall_new & ~rise_keep)
                   | (~fall_new & rise_new & fall_keep)
                   | (~fall_new & ~rise_new & order);

    // First pending channel at or after rr_ptr, wrapping at N_CH.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (sum >= (CH_W+1)'(N_CH)) begin
                sum = sum - (CH_W+1)'(N_CH);
            end
            idx = sum[CH_W-1:0];
            if (!found && any_pend[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        pick_type = fall_pend[pick];
        if (rise_pend[pick] && fall_pend[pick]) begin
            pick_type = order[pick];
        end
    end

    assign rr_next = (evt_ch == CH_W'(N_CH - 1)) ? '0 : evt_ch + CH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            rise_pend <= '0;
            fall_pend <= '0;
            order     <= '0;
            ovf       <= '0;
        end else begin
            sync1     <= data_in;
            sync2     <= sync1;
            prev      <= sync2;
            rise_pend <= rise_keep | rise_det;
            fall_pend <= fall_keep | fall_det;
            order     <= order_n;
            // set wins over clear
            ovf       <= (ovf & ~ovf_clr)
                       | (rise_det & rise_keep)
                       | (fall_det & fall_keep);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_type  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        evt_valid <= 1'b1;
                        evt_ch    <= pick;
                        evt_type  <= pick_type;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        rr_ptr    <= rr_next;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: random and directed stimulus against a
// queue-based event model of the edge event arbiter.
module tb_edge_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] data_in;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_ch;
    logic         evt_type;
    logic [N-1:0] ovf;
    logic [N-1:0] ovf_clr;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(N), .CH_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_type  (evt_type),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    int checks   = 0;
    int failures = 0;

    // pq[i]: pending event types of channel i, oldest first
    bit           pq[N][$];
    bit [N-1:0]   h0, h1, h2;
    bit [N-1:0]   m_ovf;
    int           m_rr;
    bit           m_valid;
    int           m_ch;
    bit           m_type;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) pq[i].delete();
        h0 = '0;
        h1 = '0;
        h2 = '0;
        m_ovf = '0;
        m_rr = 0;
        m_valid = 1'b0;
        m_ch = 0;
        m_type = 1'b0;
    endtask

    function automatic bit has(input int c, input bit t);
        for (int j = 0; j < pq[c].size(); j++)
            if (pq[c][j] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Queue an event; returns 1 when it collides with a pending one.
    function automatic bit add(input int c, input bit t);
        if (has(c, t)) return 1'b1;
        pq[c].push_back(t);
        return 1'b0;
    endfunction

    // Advance the model across the next rising edge using current inputs.
    task automatic m_step();
        int g;
        int c;
        bit set;
        if (!rst_n) begin
            m_reset();
            return;
        end
        g = -1;
        if (!m_valid) begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (g < 0 && pq[c].size() > 0) g = c;
            end
        end
        if (m_valid && evt_ready) begin
            for (int j = 0; j < pq[m_ch].size(); j++) begin
                if (pq[m_ch][j] == m_type) begin
                    pq[m_ch].delete(j);
                    break;
                end
            end
            m_valid = 1'b0;
            m_rr = (m_ch + 1) % N;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_ch = g;
            m_type = pq[g][0];
        end
        for (int i = 0; i < N; i++) begin
            set = 1'b0;
            if (h1[i] && !h2[i] && rise_en[i]) set |= add(i, 1'b0);
            if (!h1[i] && h2[i] && fall_en[i]) set |= add(i, 1'b1);
            m_ovf[i] = (m_ovf[i] & ~ovf_clr[i]) | set;
        end
        h2 = h1;
        h1 = h0;
        h0 = data_in;
    endtask

    task automatic cmp_all();
        chk("valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) begin
            chk("ch", 32'(evt_ch), 32'(m_ch));
            chk("type", 32'(evt_type), 32'(m_type));
        end
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic cycle();
        m_step();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    int  cnt;
    bit  seen;
    int  bias;

    initial begin
        rst_n     = 1'b0;
        data_in   = '0;
        rise_en   = '1;
        fall_en   = '1;
        evt_ready = 1'b0;
        ovf_clr   = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 32'(0));
        chk("rst_ch", 32'(evt_ch), 32'(0));
        chk("rst_type", 32'(evt_type), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        rst_n = 1'b1;

        // single rise on ch1: valid after the fourth edge, for one cycle
        evt_ready  = 1'b1;
        data_in[1] = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 10) begin
            cycle();
            cnt++;
            if (evt_valid) seen = 1'b1;
        end
        chk("t1_lat", 32'(cnt), 32'(4));
        chk("t1_ch", 32'(evt_ch), 32'(1));
        cycle();
        chk("t1_one", 32'(evt_valid), 32'(0));
        repeat (4) cycle();

        // all channels rise together -> round robin
        data_in = '1;
        repeat (14) cycle();

        // overflow on ch2 under backpressure
        data_in   = '0;
        repeat (12) cycle();
        evt_ready = 1'b0;
        data_in[2] = 1'b1;
        repeat (2) cycle();
        data_in[2] = 1'b0;
        repeat (2) cycle();
        data_in[2] = 1'b1;
        repeat (12) cycle();
        chk("t4_ovf", 32'(ovf[2]), 32'(1));
        evt_ready = 1'b1;
        repeat (10) cycle();
        ovf_clr[2] = 1'b1;
        cycle();
        ovf_clr = '0;
        chk("t4_clr", 32'(ovf[2]), 32'(0));

        // enables: no fall on ch0, rise only
        fall_en[0] = 1'b0;
        data_in[0] = 1'b1;
        repeat (6) cycle();
        data_in[0] = 1'b0;
        repeat (6) cycle();
        fall_en = '1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) bias = $urandom_range(0, 4);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) data_in[i] = ~data_in[i];
            if ($urandom_range(0, 31) == 0) rise_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) fall_en = 4'($urandom);
            evt_ready = ($urandom_range(0, 3) < bias);
            ovf_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : '0;
            cycle();
        end
        ovf_clr = '0;

        // async reset while an event is presented
        rise_en   = '1;
        fall_en   = '1;
        evt_ready = 1'b0;
        data_in   = ~data_in;
        cnt = 0;
        while (!m_valid && cnt < 50) begin
            cycle();
            cnt++;
        end
        chk("t6_pre", 32'(evt_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(evt_valid), 32'(0));
        chk("t6_ovf", 32'(ovf), 32'(0));
        m_reset();
        @(negedge clk);
        cmp_all();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        repeat (40) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
